// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer sharing one D_MEM between the MEM stage (A) and the loader (B)
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_done,
  output logic              stall,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("MEM_LATENCY must be 1..15");
  end
  state_t state, state_nx;
  logic [3:0] cnt;
  logic gnt_b, last_b, lat_we, pick_b, start;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  // B wins only when A is absent or A was served last
  assign pick_b = b_req & (~a_req | ~last_b);
  assign start  = state == IDLE && (a_req || b_req);
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next-state: IDLE -> ACCESS for the held latency -> one DONE cycle -> IDLE
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? ACCESS : IDLE;
      ACCESS:  state_nx = cnt == 4'd0 ? DONE : ACCESS;
      default: state_nx = IDLE;
    endcase
  end
  // request latch, latency counter, grant history and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      gnt_b     <= 1'b0;
      last_b    <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else if (start) begin
      gnt_b     <= pick_b;
      lat_we    <= pick_b ? b_we : a_we;
      lat_addr  <= pick_b ? b_addr : a_addr;
      lat_wdata <= pick_b ? b_wdata : a_wdata;
      cnt       <= CNT_LOAD;
    end else if (state == ACCESS) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else begin
        last_b <= gnt_b;
        if (!lat_we && gnt_b) b_rdata <= mem_read_data;
        if (!lat_we && !gnt_b) a_rdata <= mem_read_data;
      end
    end
  end
  // memory strobes only during ACCESS, done pulse in DONE, stall until A's done
  always_comb begin
    mem_address    = lat_addr;
    mem_write_data = lat_wdata;
    mem_MemRead    = state == ACCESS && !lat_we;
    mem_MemWrite   = state == ACCESS && lat_we;
    a_done         = state == DONE && !gnt_b;
    b_done         = state == DONE && gnt_b;
    stall          = a_req && !a_done;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a transaction-level model of the arbiter
module tb_dmem_arbiter;
  localparam int L = 2;
  logic clk = 0, rst = 1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic [31:0] a_rdata, b_rdata, mem_address, mem_write_data, mem_read_data;
  logic a_done, b_done, stall, mem_MemWrite, mem_MemRead;
  logic c_req = 0;
  logic [31:0] c_addr = 0;
  logic [31:0] d1_ard, d1_brd, d1_addr, d1_wd, d1_rdata;
  logic d1_adone, d1_bdone, d1_stall, d1_mw, d1_mr;
  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] dmem [256];
  logic [31:0] ref_mem [256];
  int wcnt = 0;
  bit chk_en = 0;
  bit m_busy = 0, m_gnt = 0, m_we = 0, m_last = 1;
  int m_t0 = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_ard = 0, m_brd = 0;
  int nrd, nwr, nst;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done), .stall(stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_done(b_done),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_read_data(mem_read_data));

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_req(c_req), .a_we(1'b0), .a_addr(c_addr), .a_wdata(32'h0),
    .a_rdata(d1_ard), .a_done(d1_adone), .stall(d1_stall),
    .b_req(1'b0), .b_we(1'b0), .b_addr(32'h0), .b_wdata(32'h0),
    .b_rdata(d1_brd), .b_done(d1_bdone),
    .mem_address(d1_addr), .mem_write_data(d1_wd),
    .mem_MemWrite(d1_mw), .mem_MemRead(d1_mr),
    .mem_read_data(d1_rdata));

  assign d1_rdata = d1_addr ^ 32'hA5A5A5A5;
  assign mem_read_data = dmem[mem_address[9:2]];

  // D_MEM stand-in: shares the system reset and commits a store at the end of its final held cycle
  always @(posedge clk) begin
    if (rst || !mem_MemWrite) wcnt <= 0;
    else begin
      wcnt <= wcnt + 1;
      if (wcnt == L - 1) dmem[mem_address[9:2]] <= mem_write_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // transaction model: one access occupies cycles t0..t0+L-1 with strobes, done at t0+L, idle again at t0+L+1
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      chk_en = 1; m_busy = 0; m_ard = 0; m_brd = 0; m_last = 1;
    end else if (!m_busy) begin
      if (a_req || b_req) begin
        m_gnt   = (a_req && b_req) ? !m_last : b_req;
        m_we    = m_gnt ? b_we : a_we;
        m_addr  = m_gnt ? b_addr : a_addr;
        m_wdata = m_gnt ? b_wdata : a_wdata;
        m_t0 = cyc; m_busy = 1;
      end
    end else if (cyc == m_t0 + L) begin
      if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
      else if (m_gnt) m_brd = ref_mem[m_addr[9:2]];
      else m_ard = ref_mem[m_addr[9:2]];
      m_last = m_gnt;
    end else if (cyc == m_t0 + L + 1) m_busy = 0;
  end

  // every-cycle comparison against the model
  always @(negedge clk) if (chk_en) begin
    automatic int d = cyc - m_t0;
    automatic bit e_acc = m_busy && d < L;
    automatic bit e_done = m_busy && d == L;
    chk("mem_MemRead", 32'(mem_MemRead), 32'(e_acc && !m_we));
    chk("mem_MemWrite", 32'(mem_MemWrite), 32'(e_acc && m_we));
    chk("a_done", 32'(a_done), 32'(e_done && !m_gnt));
    chk("b_done", 32'(b_done), 32'(e_done && m_gnt));
    chk("stall", 32'(stall), 32'(a_req && !(e_done && !m_gnt)));
    chk("a_rdata", a_rdata, m_ard);
    chk("b_rdata", b_rdata, m_brd);
    if (e_acc) chk("mem_address", mem_address, m_addr);
    if (e_acc && m_we) chk("mem_write_data", mem_write_data, m_wdata);
  end

  // one transaction on port A (port=0) or B (port=1); lat = cycles from request to done
  task automatic access(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wd, output int lat);
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    lat = 0; nrd = 0; nwr = 0; nst = 0;
    forever begin
      @(negedge clk);
      nrd += int'(mem_MemRead); nwr += int'(mem_MemWrite); nst += int'(stall);
      if (port ? b_done : a_done) break;
      lat++;
      if (lat > 40) begin chk("access_timeout", 32'(lat), 32'(L + 1)); break; end
    end
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
  endtask

  initial begin
    automatic int lat;
    automatic int seq [$];
    automatic int dc [$];
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
      ref_mem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
    end
    dmem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_write_data", mem_write_data, 0);
    chk("rst_strobes", {30'b0, mem_MemRead, mem_MemWrite}, 0);
    chk("rst_dones", {30'b0, a_done, b_done}, 0);
    @(posedge clk); #1 rst = 0;
    access(0, 0, 32'h10, 0, lat);
    chk("rd_latency", 32'(lat), 3);
    chk("rd_memread_cycles", 32'(nrd), 2);
    chk("rd_stall_cycles", 32'(nst), 3);
    chk("rd_data", a_rdata, 32'hDEADBEEF);
    access(1, 1, 32'h20, 32'h12345678, lat);
    chk("wr_memwrite_cycles", 32'(nwr), 2);
    chk("wr_b_rdata", b_rdata, 0);
    access(0, 0, 32'h20, 0, lat);
    chk("rd_after_wr", a_rdata, 32'h12345678);
    chk("b_rdata_kept", b_rdata, 0);
    rst = 1; a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 32'h10; b_addr = 32'h20;
    @(posedge clk); #1 rst = 0;
    for (int n = 0; n < 60 && seq.size() < 4; n++) begin
      @(negedge clk);
      if (a_done) seq.push_back(0);
      if (b_done) seq.push_back(1);
    end
    @(posedge clk); #1 a_req = 0; b_req = 0;
    chk("rr_count", 32'(seq.size()), 4);
    if (seq.size() == 4) chk("rr_order", 32'({seq[0][0], seq[1][0], seq[2][0], seq[3][0]}), 32'b0101);
    chk("rr_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("rr_b_rdata", b_rdata, 32'h12345678);
    access(1, 0, 32'h10, 0, lat);
    chk("b_only_stall", 32'(nst), 0);
    a_req = 1; a_we = 1; a_addr = 32'h10; a_wdata = 32'h55555555;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; a_req = 0;
    @(negedge clk);
    chk("abort_memwrite", 32'(mem_MemWrite), 0);
    chk("abort_a_done", 32'(a_done), 0);
    chk("abort_a_rdata", a_rdata, 0);
    @(posedge clk); #1;
    access(0, 0, 32'h10, 0, lat);
    chk("abort_preserved", a_rdata, 32'hDEADBEEF);
    c_req = 1; c_addr = 32'h40; lat = 0; nrd = 0;
    for (int n = 0; n < 60 && dc.size() < 3; n++) begin
      @(negedge clk);
      nrd += int'(d1_mr);
      if (n == 0) chk("l1_stall", 32'(d1_stall), 1);
      if (d1_adone) dc.push_back(cyc);
      else if (dc.size() == 0) lat++;
    end
    @(posedge clk); #1 c_req = 0;
    chk("l1_latency", 32'(lat), 2);
    chk("l1_count", 32'(dc.size()), 3);
    if (dc.size() == 3) begin
      chk("l1_spacing1", 32'(dc[1] - dc[0]), 3);
      chk("l1_spacing2", 32'(dc[2] - dc[1]), 3);
    end
    chk("l1_memread_cycles", 32'(nrd), 3);
    chk("l1_rdata", d1_ard, 32'hA5A5A5E5);
    chk("l1_b_side", {d1_brd[31:2], d1_bdone, d1_mw}, 0);
    chk("l1_wdata", d1_wd, 0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
